// File: rtl/risc_v_mike_uart_mmio.sv
// Memory-mapped bridge between the core load/store path and UART_MIKE:
// TX/RX flag handshakes, an RX byte FIFO and sticky status bits.
module risc_v_mike_uart_mmio #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0100,
    parameter int          RX_FIFO_DEPTH = 4,
    parameter int          DATA_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       bus_addr,
    input  logic              bus_write,
    input  logic              bus_read,
    input  logic [31:0]       bus_wr_data,
    output logic [31:0]       bus_rd_data,
    output logic              bus_hit,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_send,
    input  logic              tx_flag,
    output logic              tx_flag_clr,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_flag,
    output logic              rx_flag_clr,
    input  logic              parity_error
);
    localparam int               PTR_W    = $clog2(RX_FIFO_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_FIFO_DEPTH);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_RXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    typedef enum logic [1:0] { TX_IDLE, TX_SEND, TX_WAIT, TX_CLR } tx_state_t;
    typedef enum logic { RX_IDLE, RX_ACK } rx_state_t;

    tx_state_t tx_state, tx_state_nxt;
    rx_state_t rx_state, rx_state_nxt;
    logic      tx_clr_q, rx_clr_q;

    logic [DATA_W-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              rx_ovr, par_err, tx_drop;

    logic [1:0]  offset;
    logic        wr_acc, rd_acc;
    logic        tx_wr, sts_wr, flush, pop_req;
    logic        rx_push, rx_nempty, rx_full, tx_busy;
    logic        pop, push_ok, push_ovr;
    logic [31:0] status_word;
    logic        unused_bits;

    assign bus_hit = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign offset  = bus_addr[3:2];
    // A simultaneous read and write is treated as a write only.
    assign wr_acc  = bus_hit && bus_write;
    assign rd_acc  = bus_hit && bus_read && !bus_write;
    assign tx_wr   = wr_acc && (offset == OFF_TXDATA);
    assign sts_wr  = wr_acc && (offset == OFF_STATUS);
    assign flush   = wr_acc && (offset == OFF_CTRL) && bus_wr_data[0];
    assign pop_req = rd_acc && (offset == OFF_RXDATA);

    assign rx_nempty = (count != '0);
    assign rx_full   = (count == FULL_CNT);
    assign tx_busy   = (tx_state != TX_IDLE);
    assign rx_push   = (rx_state == RX_IDLE) && rx_flag;
    // A pop frees a slot in the same edge, so full+pop+push is not an overrun.
    assign pop       = pop_req && rx_nempty && !flush;
    assign push_ok   = rx_push && !flush && (!rx_full || pop);
    assign push_ovr  = rx_push && !flush && rx_full && !pop;

    assign status_word = {26'd0, tx_drop, par_err, rx_ovr, rx_full, tx_busy, rx_nempty};
    assign unused_bits = ^{bus_addr[1:0], bus_wr_data};

    always_comb begin
        bus_rd_data = '0;
        if (bus_hit) begin
            case (offset)
                OFF_RXDATA: if (rx_nempty) bus_rd_data = {{(32-DATA_W){1'b0}}, fifo_mem[rd_ptr]};
                OFF_STATUS: bus_rd_data = status_word;
                default:    bus_rd_data = '0;
            endcase
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_send      = 1'b0;
        tx_flag_clr  = 1'b0;
        case (tx_state)
            TX_IDLE: if (tx_wr) tx_state_nxt = TX_SEND;
            TX_SEND: begin
                tx_send      = 1'b1;
                tx_state_nxt = TX_WAIT;
            end
            TX_WAIT: if (tx_flag) tx_state_nxt = TX_CLR;
            TX_CLR: begin
                tx_flag_clr = !tx_clr_q;
                if (!tx_flag) tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_flag_clr  = 1'b0;
        case (rx_state)
            RX_IDLE: if (rx_flag) rx_state_nxt = RX_ACK;
            RX_ACK: begin
                // Clear pulse only on the first ACK cycle, never re-issued while waiting.
                rx_flag_clr = !rx_clr_q;
                if (!rx_flag) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
            tx_clr_q <= 1'b0;
            rx_clr_q <= 1'b0;
            tx_data  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rx_ovr   <= 1'b0;
            par_err  <= 1'b0;
            tx_drop  <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            rx_state <= rx_state_nxt;
            tx_clr_q <= (tx_state == TX_CLR);
            rx_clr_q <= (rx_state == RX_ACK);
            if (tx_wr && !tx_busy) tx_data <= bus_wr_data[DATA_W-1:0];
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                count <= count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
            end
            rx_ovr  <= push_ovr | (rx_ovr & ~(sts_wr & bus_wr_data[3]));
            par_err <= (rx_push & parity_error) | (par_err & ~(sts_wr & bus_wr_data[4]));
            tx_drop <= (tx_wr & tx_busy) | (tx_drop & ~(sts_wr & bus_wr_data[5]));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= rx_data;
    end

endmodule

// File: tb/tb_risc_v_mike_uart_mmio.sv
// Directed bench for risc_v_mike_uart_mmio with a UART stand-in and an RX byte scoreboard.
module tb_risc_v_mike_uart_mmio;
    localparam logic [31:0] A_TX  = 32'h0000_0100;
    localparam logic [31:0] A_RX  = 32'h0000_0104;
    localparam logic [31:0] A_STS = 32'h0000_0108;
    localparam logic [31:0] A_CTL = 32'h0000_010C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
    logic        bus_write, bus_read, bus_hit;
    logic [7:0]  tx_data, rx_data;
    logic        tx_send, tx_flag, tx_flag_clr, rx_flag, rx_flag_clr, parity_error;

    int          tests = 0;
    int          fails = 0;
    int          tx_send_cnt = 0;
    int          tx_clr_cnt = 0;
    int          rx_clr_cnt = 0;
    logic [7:0]  last_tx = 8'h00;
    logic [7:0]  rx_exp[$];

    risc_v_mike_uart_mmio dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_write(bus_write),
        .bus_read(bus_read), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
        .bus_hit(bus_hit), .tx_data(tx_data), .tx_send(tx_send), .tx_flag(tx_flag),
        .tx_flag_clr(tx_flag_clr), .rx_data(rx_data), .rx_flag(rx_flag),
        .rx_flag_clr(rx_flag_clr), .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_send) begin
            tx_send_cnt <= tx_send_cnt + 1;
            last_tx     <= tx_data;
        end
        if (tx_flag_clr) tx_clr_cnt <= tx_clr_cnt + 1;
        if (rx_flag_clr) rx_clr_cnt <= rx_clr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        bus_addr = addr; bus_wr_data = data; bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0; bus_wr_data = '0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        bus_addr = addr; bus_read = 1'b1;
        #1 data = bus_rd_data;
        @(negedge clk);
        bus_read = 1'b0;
    endtask

    function automatic logic [31:0] next_rx();
        if (rx_exp.size() == 0) return 32'h0;
        return {24'h0, rx_exp.pop_front()};
    endfunction

    task automatic tx_complete(input string tag);
        bit seen = 0;
        tx_flag = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (tx_flag_clr) seen = 1;
        end
        check({tag, "_clr_seen"}, 32'(seen), 32'd1);
        tx_flag = 1'b0;
        @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic par, input int hold, input bit expect_kept);
        bit seen = 0;
        rx_data = b; parity_error = par; rx_flag = 1'b1;
        if (expect_kept) rx_exp.push_back(b);
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (rx_flag_clr) seen = 1;
        end
        check("rx_ack_seen", 32'(seen), 32'd1);
        repeat (hold) @(negedge clk);
        rx_flag = 1'b0; parity_error = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        int          base;
        rst = 1'b1; bus_addr = '0; bus_write = 0; bus_read = 0; bus_wr_data = '0;
        tx_flag = 0; rx_flag = 0; rx_data = '0; parity_error = 0;
        repeat (3) @(negedge clk);

        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_tx_clr", 32'(tx_flag_clr), 32'd0);
        check("rst_rx_clr", 32'(rx_flag_clr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("miss_hit", 32'(bus_hit), 32'd0);
        check("miss_rdata", bus_rd_data, 32'd0);
        bus_addr = A_STS;
        #1 check("rst_status", bus_rd_data, 32'd0);
        check("win_hit", 32'(bus_hit), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: single transmit
        base = tx_send_cnt;
        bus_wr(A_TX, 32'h0000_0055);
        check("t1_send_high", 32'(tx_send), 32'd1);
        check("t1_tx_data", 32'(tx_data), 32'h55);
        @(negedge clk);
        check("t1_send_low", 32'(tx_send), 32'd0);
        check("t1_send_count", 32'(tx_send_cnt - base), 32'd1);
        check("t1_sent_byte", 32'(last_tx), 32'h55);
        bus_rd(A_STS, rd);
        check("t1_busy", rd, 32'h02);
        base = tx_clr_cnt;
        tx_complete("t1");
        check("t1_clr_count", 32'(tx_clr_cnt - base), 32'd1);
        bus_rd(A_STS, rd);
        check("t1_idle", rd, 32'h00);

        // 2: write while busy is dropped
        base = tx_send_cnt;
        bus_wr(A_TX, 32'h0000_0011);
        bus_wr(A_TX, 32'h0000_0022);
        bus_rd(A_STS, rd);
        check("t2_status", rd, 32'h22);
        check("t2_tx_data", 32'(tx_data), 32'h11);
        tx_complete("t2");
        check("t2_send_count", 32'(tx_send_cnt - base), 32'd1);
        check("t2_sent_byte", 32'(last_tx), 32'h11);
        bus_wr(A_STS, 32'h0000_0020);
        bus_rd(A_STS + 32'd2, rd);
        check("t2_drop_clr", rd, 32'h00);

        // 3: three received bytes, first one held high after its ack
        base = rx_clr_cnt;
        rx_byte(8'hA1, 1'b0, 3, 1'b1);
        check("t3_single_clr", 32'(rx_clr_cnt - base), 32'd1);
        rx_byte(8'hA2, 1'b0, 0, 1'b1);
        rx_byte(8'hA3, 1'b0, 0, 1'b1);
        check("t3_clr_count", 32'(rx_clr_cnt - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            bus_rd(A_RX, rd);
            check("t3_rxdata", rd, next_rx());
        end
        bus_rd(A_RX, rd);
        check("t3_empty_read", rd, next_rx());
        bus_rd(A_STS, rd);
        check("t3_status", rd, 32'h00);

        // 4: overrun on the fifth byte
        for (int i = 0; i < 5; i++) rx_byte(8'hB0 + 8'(i), 1'b0, 0, i < 4);
        bus_rd(A_STS, rd);
        check("t4_status", rd, 32'h0D);
        for (int i = 0; i < 5; i++) begin
            bus_rd(A_RX + 32'd1, rd);
            check("t4_rxdata", rd, next_rx());
        end
        bus_wr(A_STS, 32'h0000_0008);
        bus_rd(A_STS, rd);
        check("t4_ovr_clr", rd, 32'h00);

        // 5: full FIFO, pop and push on the same edge
        for (int i = 0; i < 4; i++) rx_byte(8'hC0 + 8'(i), 1'b0, 0, 1'b1);
        rx_data = 8'hC4; rx_flag = 1'b1;
        bus_addr = A_RX; bus_read = 1'b1;
        #1 check("t5_head", bus_rd_data, next_rx());
        rx_exp.push_back(8'hC4);
        @(negedge clk);
        bus_read = 1'b0;
        check("t5_ack", 32'(rx_flag_clr), 32'd1);
        rx_flag = 1'b0;
        @(negedge clk);
        bus_rd(A_STS, rd);
        check("t5_status", rd, 32'h05);
        for (int i = 0; i < 4; i++) begin
            bus_rd(A_RX, rd);
            check("t5_order", rd, next_rx());
        end

        // 6: parity error, flush, reset during TX wait
        rx_byte(8'h7E, 1'b1, 0, 1'b1);
        bus_rd(A_STS, rd);
        check("t6_par_status", rd, 32'h11);
        bus_wr(A_CTL, 32'h0000_0001);
        rx_exp.delete();
        bus_rd(A_STS, rd);
        check("t6_flushed", rd, 32'h10);
        bus_rd(A_RX, rd);
        check("t6_flush_read", rd, next_rx());
        bus_wr(A_STS, 32'h0000_0010);

        bus_wr(A_TX, 32'h0000_003C);
        @(negedge clk);
        @(negedge clk);
        rx_data = 8'h99; rx_flag = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus_addr = A_STS;
        #1;
        check("t6_rst_status", bus_rd_data, 32'h00);
        check("t6_rst_tx_data", 32'(tx_data), 32'd0);
        check("t6_rst_send", 32'(tx_send), 32'd0);
        check("t6_rst_rx_clr", 32'(rx_flag_clr), 32'd0);
        rst = 1'b0;
        rx_exp.push_back(8'h99);
        @(negedge clk);
        check("t6_recapture_ack", 32'(rx_flag_clr), 32'd1);
        rx_flag = 1'b0;
        @(negedge clk);
        bus_rd(A_RX, rd);
        check("t6_recapture_byte", rd, next_rx());
        bus_rd(A_STS, rd);
        check("t6_final_status", rd, 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
